memory_access_stage: RTL and testbench
======================================

Name: memory_access_stage

Overview:
Pipeline MEM stage directly upstream of the write-back stage.
- Performs load/store accesses to data memory over a ready-based handshake.
- Formats load data for byte, half and word accesses, with sign or zero extension.
- Detects misaligned accesses and access timeouts.
- Stalls the upstream pipeline while an access is outstanding.
- Owns the MEM/WB pipeline register that drives the write-back stage inputs.

Parameters:
- WORD_SIZE, 32, datapath width; taken from the shared WORD_SIZE constant.
- TIMEOUT, 16, maximum number of cycles to wait for mem_ready before declaring a bus error.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-low (rst==0 resets on the rising clk edge).
- ValidM  in  1  the M-stage slot holds a real instruction.
- ALUResultM  in  WORD_SIZE  ALU result; also the effective address.
- WriteDataM  in  WORD_SIZE  store data, unaligned, in bits [7:0]/[15:0]/[31:0].
- PCPlus4M  in  WORD_SIZE  PC+4 passthrough.
- ResultSrcM  in  2  00 = ALU, 01 = load, 10 = PC+4.
- MemWriteM  in  1  store.
- Funct3M  in  3  000 = b, 001 = h, 010 = w, 100 = bu, 101 = hu.
- RdM  in  5  destination register.
- RegWriteM  in  1  register write enable.
- mem_req  out  1  access request.
- mem_we  out  1  write access.
- mem_addr  out  WORD_SIZE  word-aligned address ({ALUResultM[31:2],2'b00}).
- mem_wdata  out  WORD_SIZE  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_rdata  in  WORD_SIZE  read data, valid when mem_ready==1.
- mem_ready  in  1  access completes this cycle.
- StallM  out  1  hold fetch/decode/execute and the M inputs.
- RdMH  out  5  forwarding/hazard copy of RdM.
- RegWriteMH  out  1  forwarding/hazard copy of RegWriteM & ValidM.
- ALUResultW, ReadDataW, PCPlus4W  out  WORD_SIZE  MEM/WB register outputs.
- ResultSrcW  out  2  MEM/WB register output.
- RdW  out  5  MEM/WB register output.
- RegWriteW  out  1  MEM/WB register output.
- MisalignW  out  1  one-cycle flag, registered with the faulting instruction.
- BusErrW  out  1  one-cycle flag, registered with the timed-out instruction.

Behaviour:
- access = ValidM & (MemWriteM | ResultSrcM==01).
- misaligned = (h/hu & addr[0]) | (w & addr[1:0]!=0).
- FSM states: IDLE, WAIT.
- IDLE, access & !misaligned:
  - mem_req=1 combinationally.
  - mem_ready=1 → completes this cycle, stay IDLE.
  - mem_ready=0 → go to WAIT, counter=1.
- WAIT:
  - mem_req=1, with address, data and enables held from the stalled M inputs.
  - mem_ready=1 → complete, go to IDLE.
  - counter==TIMEOUT-1 without ready → abort, go to IDLE, BusErrW=1 next cycle.
  - otherwise counter++.
- StallM = mem_req & ~mem_ready & ~timeout_abort. StallM is 0 whenever rst==0.
- Store enables/data:
  - sb: mem_be = 4'b0001<<addr[1:0]; byte replicated on all 4 lanes.
  - sh: mem_be = addr[1] ? 1100 : 0011; half replicated on both halves.
  - sw: mem_be = 1111.
- Load enables: same enables as the matching store.
- Load data (ReadDataW):
  - lane extracted from mem_rdata by addr.
  - b/h sign-extended; bu/hu zero-extended; w passed through.
- MEM/WB register, updated every clk edge:
  - Stall cycle (StallM==1): load a bubble (RegWriteW=0, RdW=0, ResultSrcW=00, flags 0).
  - Non-memory ValidM instruction: passes through in 1 cycle.
  - Memory instruction: passes through on its completion cycle.
  - Misaligned access: mem_req never asserted; RegWriteW=0; MisalignW=1.
  - Bus error: RegWriteW=0; BusErrW=1.
  - ValidM==0: bubble.
  - RegWriteW is forced to 0 when RdM==0.
- Reset (rst==0 at edge): state=IDLE, counter=0, all W outputs = 0.
  - mem_req is forced to 0 while rst==0.
  - Reset during WAIT abandons the access; no WB write occurs.
- Latency: non-memory and zero-wait accesses take 1 cycle; waited accesses take N+1 cycles.

Decomposition:
- Shared package/constants:
  - WORD_SIZE.
  - Funct3 load/store size codes.
  - ResultSrc encodings.
  - FSM state encodings.
- One natural sub-module: load_store_align (combinational).
  - Inputs: Funct3, addr[1:0], WriteData, mem_rdata.
  - Outputs: mem_be, mem_wdata, formatted ReadData, misaligned.

Test Plan:
- ALU op, ALUResultM=0x1234, RdM=5, RegWriteM=1 → next cycle ALUResultW=0x1234, RdW=5, RegWriteW=1, mem_req never asserted.
- lb at addr 0x103, mem_rdata=0x80FFFFFF, ready same cycle → ReadDataW=0xFFFFFF80; lbu → 0x00000080; mem_be=1000.
- sh at 0x102, WriteDataM=0xABCD, mem_ready held low for 3 cycles → StallM=1 for 3 cycles; mem_wdata=0xABCDABCD, mem_be=1100 stable throughout; 3 bubbles at WB.
- lw at 0x101 → no mem_req; next cycle MisalignW=1, RegWriteW=0.
- lw with mem_ready held 0 (TIMEOUT=16) → StallM high 15 cycles, then BusErrW=1, RegWriteW=0, FSM back in IDLE.
- rst driven 0 during WAIT → mem_req=0 immediately, all W outputs 0 after the edge; after rst returns to 1, the next lw completes normally.

Source files
------------

// File: rtl/memory_access_stage_pkg.sv
// Shared constants for the MEM stage: datapath width, access-size codes,
// write-back source encodings and the access FSM states.
package memory_access_stage_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU  = 2'b00;
  localparam logic [1:0] RS_LOAD = 2'b01;
  localparam logic [1:0] RS_PC4  = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  // Bit 2 of funct3 only selects zero extension; size lives in the low bits.
  function automatic size_e f3_size(input logic [2:0] f3);
    if (f3[1])
      return SZ_WORD;
    else if (f3[0])
      return SZ_HALF;
    else
      return SZ_BYTE;
  endfunction

endpackage

// File: rtl/memory_access_stage_load_store_align.sv
// Byte-lane steering for loads and stores: enables, replicated store data,
// extracted/extended load data and the alignment check.
module memory_access_stage_load_store_align
  import memory_access_stage_pkg::*;
(
  input  logic [2:0]           i_funct3,
  input  logic [1:0]           i_addr_lo,
  input  logic [WORD_SIZE-1:0] i_wdata,
  input  logic [WORD_SIZE-1:0] i_rdata,
  output logic [3:0]           o_be,
  output logic [WORD_SIZE-1:0] o_wdata,
  output logic [WORD_SIZE-1:0] o_rdata,
  output logic                 o_misaligned
);

  size_e       w_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_size       = f3_size(i_funct3);
    w_byte       = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half       = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_be         = 4'b1111;
    o_wdata      = i_wdata;
    o_rdata      = i_rdata;
    o_misaligned = 1'b0;
    case (w_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = i_funct3[2] ? {{(WORD_SIZE-8){1'b0}}, w_byte}
                              : {{(WORD_SIZE-8){w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wdata[15:0]}};
        o_rdata      = i_funct3[2] ? {{(WORD_SIZE-16){1'b0}}, w_half}
                                   : {{(WORD_SIZE-16){w_half[15]}}, w_half};
        o_misaligned = i_addr_lo[0];
      end
      default: begin
        o_misaligned = |i_addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Pipeline MEM stage: data-memory handshake with timeout, upstream stall
// generation and the MEM/WB register feeding write-back.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ValidM,
  input  logic [WORD_SIZE-1:0] ALUResultM,
  input  logic [WORD_SIZE-1:0] WriteDataM,
  input  logic [WORD_SIZE-1:0] PCPlus4M,
  input  logic [1:0]           ResultSrcM,
  input  logic                 MemWriteM,
  input  logic [2:0]           Funct3M,
  input  logic [4:0]           RdM,
  input  logic                 RegWriteM,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic [3:0]           mem_be,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 StallM,
  output logic [4:0]           RdMH,
  output logic                 RegWriteMH,
  output logic [WORD_SIZE-1:0] ALUResultW,
  output logic [WORD_SIZE-1:0] ReadDataW,
  output logic [WORD_SIZE-1:0] PCPlus4W,
  output logic [1:0]           ResultSrcW,
  output logic [4:0]           RdW,
  output logic                 RegWriteW,
  output logic                 MisalignW,
  output logic                 BusErrW
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [0:0]           r_state;
  logic [CW-1:0]        r_count;
  logic [WORD_SIZE-1:0] r_alu, r_rdata, r_pc4;
  logic [1:0]           r_rsrc;
  logic [4:0]           r_rd;
  logic                 r_regwrite, r_misalign, r_buserr;

  logic                 w_access, w_misaligned, w_mis_access;
  logic                 w_req, w_stall, w_timeout_abort, w_fault;
  logic [WORD_SIZE-1:0] w_rdata_fmt;

  memory_access_stage_load_store_align u_align (
    .i_funct3     (Funct3M),
    .i_addr_lo    (ALUResultM[1:0]),
    .i_wdata      (WriteDataM),
    .i_rdata      (mem_rdata),
    .o_be         (mem_be),
    .o_wdata      (mem_wdata),
    .o_rdata      (w_rdata_fmt),
    .o_misaligned (w_misaligned)
  );

  assign w_access        = ValidM & (MemWriteM | (ResultSrcM == RS_LOAD));
  assign w_mis_access    = w_access & w_misaligned;
  assign w_timeout_abort = (r_state == ST_WAIT) & ~mem_ready & (r_count == CW'(TIMEOUT - 1));
  // In WAIT the M inputs are held by the stall, so the request stays coherent.
  assign w_req           = rst & ((r_state == ST_WAIT) | (w_access & ~w_misaligned));
  assign w_stall         = w_req & ~mem_ready & ~w_timeout_abort;
  assign w_fault         = w_mis_access | w_timeout_abort;

  assign mem_req    = w_req;
  assign mem_we     = w_req & MemWriteM;
  assign mem_addr   = {ALUResultM[WORD_SIZE-1:2], 2'b00};
  assign StallM     = w_stall;
  assign RdMH       = RdM;
  assign RegWriteMH = RegWriteM & ValidM;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req & ~mem_ready) begin
            r_state <= ST_WAIT;
            r_count <= CW'(1);
          end
        end
        default: begin
          if (mem_ready | w_timeout_abort) begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || w_stall || !ValidM) begin
      r_alu      <= '0;
      r_rdata    <= '0;
      r_pc4      <= '0;
      r_rsrc     <= RS_ALU;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_misalign <= 1'b0;
      r_buserr   <= 1'b0;
    end else begin
      r_alu      <= ALUResultM;
      r_rdata    <= w_rdata_fmt;
      r_pc4      <= PCPlus4M;
      r_rsrc     <= ResultSrcM;
      r_rd       <= RdM;
      r_regwrite <= RegWriteM & (RdM != 5'd0) & ~w_fault;
      r_misalign <= w_mis_access;
      r_buserr   <= w_timeout_abort;
    end
  end

  assign ALUResultW = r_alu;
  assign ReadDataW  = r_rdata;
  assign PCPlus4W   = r_pc4;
  assign ResultSrcW = r_rsrc;
  assign RdW        = r_rd;
  assign RegWriteW  = r_regwrite;
  assign MisalignW  = r_misalign;
  assign BusErrW    = r_buserr;

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage against a behavioural model of
// instruction-level outcomes, plus directed literal cases.
module tb_memory_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        StallM;
  logic [4:0]  RdMH;
  logic        RegWriteMH;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic        RegWriteW, MisalignW, BusErrW;

  memory_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ValidM(ValidM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .Funct3M(Funct3M), .RdM(RdM), .RegWriteM(RegWriteM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .StallM(StallM),
    .RdMH(RdMH), .RegWriteMH(RegWriteMH), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W), .ResultSrcW(ResultSrcW), .RdW(RdW), .RegWriteW(RegWriteW),
    .MisalignW(MisalignW), .BusErrW(BusErrW)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] alu, wd, pc4;
    logic [1:0]  rs;
    bit          mw;
    logic [2:0]  f3;
    logic [4:0]  rd;
    bit          rw;
  } instr_t;

  int total = 0;
  int bad   = 0;

  bit          fix_rdata = 0;
  logic [31:0] fix_val   = '0;
  int          obs_stall;
  bit          obs_req_any;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_be(input logic [31:0] a, input logic [2:0] f3);
    longint m;
    m = ((64'd1 << size_of(f3)) - 1) << (a % 4);
    return m[31:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [2:0] f3);
    longint m;
    case (size_of(f3))
      1:       m = longint'(wd & 32'hFF) * 64'h01010101;
      2:       m = longint'(wd & 32'hFFFF) * 64'h00010001;
      default: m = longint'(wd);
    endcase
    return m[31:0];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [2:0] f3);
    longint v;
    int     bits;
    bits = 8 * size_of(f3);
    v = (longint'(rd) >> (8 * (a % 4))) & ((64'd1 << bits) - 1);
    if (bits < 32 && !f3[2] && ((v >> (bits - 1)) & 1) == 1)
      v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  task automatic check_bubble(input string tag);
    chk({tag, ".RegWriteW"}, {31'b0, RegWriteW}, 0);
    chk({tag, ".RdW"},       {27'b0, RdW}, 0);
    chk({tag, ".ResultSrcW"},{30'b0, ResultSrcW}, 0);
    chk({tag, ".MisalignW"}, {31'b0, MisalignW}, 0);
    chk({tag, ".BusErrW"},   {31'b0, BusErrW}, 0);
  endtask

  // One instruction through M; wait_n = cycles of mem_ready low (>= TIMEOUT: never ready).
  task automatic run(input instr_t in, input int wait_n);
    bit          access, mis, tout, load;
    int          nstall;
    logic [31:0] rd_at;
    access = in.v && (in.mw || in.rs == 2'b01);
    load   = in.v && !in.mw && in.rs == 2'b01;
    mis    = access && (in.alu % size_of(in.f3) != 0);
    tout   = access && !mis && wait_n >= TIMEOUT;
    nstall = (!access || mis) ? 0 : (tout ? TIMEOUT - 1 : wait_n);
    ValidM = in.v; ALUResultM = in.alu; WriteDataM = in.wd; PCPlus4M = in.pc4;
    ResultSrcM = in.rs; MemWriteM = in.mw; Funct3M = in.f3; RdM = in.rd; RegWriteM = in.rw;
    obs_stall = 0; obs_req_any = 0; rd_at = '0;
    for (int k = 0; k <= nstall; k++) begin
      mem_ready = (k == wait_n);
      mem_rdata = fix_rdata ? fix_val : $urandom;
      @(negedge clk);
      chk("mem_req", {31'b0, mem_req}, {31'b0, access && !mis});
      chk("StallM", {31'b0, StallM}, {31'b0, k < nstall});
      chk("RdMH", {27'b0, RdMH}, {27'b0, in.rd});
      chk("RegWriteMH", {31'b0, RegWriteMH}, {31'b0, in.rw && in.v});
      if (access && !mis) begin
        chk("mem_addr", mem_addr, in.alu & 32'hFFFF_FFFC);
        chk("mem_be", {28'b0, mem_be}, model_be(in.alu, in.f3));
        chk("mem_we", {31'b0, mem_we}, {31'b0, in.mw});
        if (in.mw) chk("mem_wdata", mem_wdata, model_wdata(in.wd, in.f3));
      end
      obs_stall   += int'(StallM);
      obs_req_any |= mem_req;
      obs_be       = mem_be;
      obs_wdata    = mem_wdata;
      rd_at        = mem_rdata;
      @(posedge clk); #1;
      if (k < nstall || !in.v) begin
        check_bubble("wb_bubble");
      end else begin
        chk("RegWriteW", {31'b0, RegWriteW},
            {31'b0, in.rw && in.rd != 0 && !mis && !tout});
        chk("MisalignW", {31'b0, MisalignW}, {31'b0, mis});
        chk("BusErrW", {31'b0, BusErrW}, {31'b0, tout});
        chk("ALUResultW", ALUResultW, in.alu);
        chk("PCPlus4W", PCPlus4W, in.pc4);
        chk("ResultSrcW", {30'b0, ResultSrcW}, {30'b0, in.rs});
        if (!mis && !tout) chk("RdW", {27'b0, RdW}, {27'b0, in.rd});
        if (load && !mis && !tout) chk("ReadDataW", ReadDataW, model_read(rd_at, in.alu, in.f3));
      end
    end
    mem_ready = 1'b0;
  endtask

  function automatic instr_t mk(input logic [31:0] alu, input logic [1:0] rs, input bit mw,
                                input logic [2:0] f3, input logic [4:0] rd, input bit rw,
                                input logic [31:0] wd);
    instr_t t;
    t.v = 1; t.alu = alu; t.rs = rs; t.mw = mw; t.f3 = f3; t.rd = rd; t.rw = rw;
    t.wd = wd; t.pc4 = alu ^ 32'h5A5A_0004;
    return t;
  endfunction

  initial begin
    instr_t t;
    int     w;
    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst = 1'b0; ValidM = 0; ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0;
    ResultSrcM = '0; MemWriteM = 0; Funct3M = '0; RdM = '0; RegWriteM = 0;
    mem_rdata = '0; mem_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_bubble("reset");
    chk("reset.ALUResultW", ALUResultW, 0);
    chk("reset.mem_req", {31'b0, mem_req}, 0);
    rst = 1'b1;

    // ALU op passes through in one cycle, no memory request
    run(mk(32'h1234, 2'b00, 0, 3'b000, 5'd5, 1, 32'h0), 0);
    chk("alu.ALUResultW", ALUResultW, 32'h1234);
    chk("alu.RdW", {27'b0, RdW}, 32'd5);
    chk("alu.RegWriteW", {31'b0, RegWriteW}, 1);
    chk("alu.no_req", {31'b0, obs_req_any}, 0);

    fix_rdata = 1; fix_val = 32'h80FF_FFFF;
    run(mk(32'h103, 2'b01, 0, 3'b000, 5'd7, 1, 32'h0), 0);
    chk("lb.ReadDataW", ReadDataW, 32'hFFFF_FF80);
    chk("lb.mem_be", {28'b0, obs_be}, 32'h8);
    run(mk(32'h103, 2'b01, 0, 3'b100, 5'd7, 1, 32'h0), 0);
    chk("lbu.ReadDataW", ReadDataW, 32'h0000_0080);
    fix_rdata = 0;

    run(mk(32'h102, 2'b00, 1, 3'b001, 5'd0, 0, 32'h0000_ABCD), 3);
    chk("sh.stall_cycles", obs_stall, 3);
    chk("sh.mem_wdata", obs_wdata, 32'hABCD_ABCD);
    chk("sh.mem_be", {28'b0, obs_be}, 32'hC);

    run(mk(32'h101, 2'b01, 0, 3'b010, 5'd9, 1, 32'h0), 0);
    chk("lw_mis.MisalignW", {31'b0, MisalignW}, 1);
    chk("lw_mis.RegWriteW", {31'b0, RegWriteW}, 0);
    chk("lw_mis.no_req", {31'b0, obs_req_any}, 0);

    run(mk(32'h200, 2'b01, 0, 3'b010, 5'd10, 1, 32'h0), 99);
    chk("lw_tout.stall_cycles", obs_stall, 15);
    chk("lw_tout.BusErrW", {31'b0, BusErrW}, 1);
    chk("lw_tout.RegWriteW", {31'b0, RegWriteW}, 0);
    run(mk(32'h204, 2'b01, 0, 3'b010, 5'd11, 1, 32'h0), 0);

    // Reset while an access is waiting
    t = mk(32'h300, 2'b01, 0, 3'b010, 5'd12, 1, 32'h0);
    ValidM = 1; ALUResultM = t.alu; PCPlus4M = t.pc4; ResultSrcM = t.rs; MemWriteM = 0;
    Funct3M = t.f3; RdM = t.rd; RegWriteM = 1; mem_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstwait.StallM_before", {31'b0, StallM}, 1);
    rst = 1'b0;
    #1;
    chk("rstwait.mem_req", {31'b0, mem_req}, 0);
    chk("rstwait.StallM", {31'b0, StallM}, 0);
    @(posedge clk); #1;
    check_bubble("rstwait");
    chk("rstwait.ALUResultW", ALUResultW, 0);
    chk("rstwait.ReadDataW", ReadDataW, 0);
    chk("rstwait.PCPlus4W", PCPlus4W, 0);
    rst = 1'b1;
    run(t, 2);
    chk("rstwait.after_RegWriteW", {31'b0, RegWriteW}, 1);

    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      t.v   = ($urandom % 10) != 0;
      t.alu = $urandom;
      if ($urandom % 2) t.alu = t.alu & 32'hFFFF_FFFC;
      t.wd  = $urandom; t.pc4 = $urandom; t.rd = 5'($urandom); t.rw = 1'($urandom);
      t.f3  = 3'($urandom); t.mw = 0;
      case (kind)
        0: t.rs = 2'b00;
        1: begin t.rs = 2'b01; t.f3 = ld_f3[$urandom_range(0, 4)]; end
        2: begin t.rs = 2'b00; t.mw = 1; t.f3 = 3'($urandom_range(0, 2)); end
        default: t.rs = 2'b10;
      endcase
      w = ($urandom % 20 == 0) ? 99 : int'($urandom % 4);
      run(t, w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
